// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART: frame state encoding, register indices,
// CTRL/STATUS bit positions and oversampling constants.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    // Register indices (PADDR[2:0])
    localparam logic [2:0] RegCtrl   = 3'd0;
    localparam logic [2:0] RegStatus = 3'd1;
    localparam logic [2:0] RegTxData = 3'd2;
    localparam logic [2:0] RegRxData = 3'd3;
    localparam logic [2:0] RegBaud   = 3'd4;

    // CTRL bit positions
    localparam int unsigned CtrlRxRst = 0;
    localparam int unsigned CtrlTxRst = 1;
    localparam int unsigned CtrlRxEn  = 2;
    localparam int unsigned CtrlTxEn  = 3;

    // STATUS bit positions
    localparam int unsigned StatTxBusy = 0;
    localparam int unsigned StatTxDone = 1;
    localparam int unsigned StatRxBusy = 2;
    localparam int unsigned StatRxDone = 3;
    localparam int unsigned StatRxErr  = 4;

    localparam int unsigned Oversample = 16;
    localparam int unsigned TickW      = $clog2(Oversample);
    localparam int unsigned BaudW      = 10;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver with 16x oversampling and a two-flop input synchronizer.
// Ports: clk_i/rst_ni clock and synchronous active-low reset; tick_i baud tick;
// en_i accept new frames; srst_i soft reset (clears done/err, keeps data);
// rx_i raw serial input; data_o last good byte; busy_o frame in progress;
// done_o sticky good-frame flag; err_o sticky framing-error flag.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         tick_i,
    input  logic         en_i,
    input  logic         srst_i,
    input  logic         rx_i,
    output logic [N-1:0] data_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam int unsigned BitW = (N > 1) ? $clog2(N) : 1;

    uart_state_e      state_q, state_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]  bit_idx_q, bit_idx_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [N-1:0]     data_q, data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rx_s1_q, rx_s1_d;
    logic             rx_s2_q, rx_s2_d;
    logic             rx_prev_q, rx_prev_d;
    logic             fall, mid_tick, last_tick;

    assign fall      = rx_prev_q && !rx_s2_q;
    // The start bit is checked half a bit in; later samples land mid-bit.
    assign mid_tick  = tick_i && (tick_cnt_q == TickW'(Oversample / 2 - 1));
    assign last_tick = tick_i && (tick_cnt_q == TickW'(Oversample - 1));

    always_comb begin
        rx_s1_d    = rx_i;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        done_d     = done_q;
        err_d      = err_q;
        if (srst_i) begin
            state_d    = StIdle;
            tick_cnt_d = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (en_i && fall) begin
                        tick_cnt_d = '0;
                        state_d    = StStart;
                    end
                end
                StStart: begin
                    if (mid_tick) begin
                        tick_cnt_d = '0;
                        if (rx_s2_q) begin
                            state_d = StIdle;  // glitch, not a start bit
                        end else begin
                            bit_idx_d = '0;
                            done_d    = 1'b0;
                            err_d     = 1'b0;
                            state_d   = StData;
                        end
                    end else if (tick_i) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (last_tick) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s2_q, shift_q[N-1:1]};
                        if (bit_idx_q == BitW'(N - 1)) begin
                            state_d = StStop;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else if (tick_i) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (last_tick) begin
                        tick_cnt_d = '0;
                        state_d    = StIdle;
                        if (rx_s2_q) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                            err_d  = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (tick_i) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign data_o = data_q;
    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, N data bits LSB first, stop bit; each bit lasts
// Oversample baud ticks.
// Ports: clk_i/rst_ni clock and synchronous active-low reset; tick_i baud tick;
// en_i start frames; srst_i soft reset (priority over en_i); data_i byte latched
// at frame start; tx_o serial line; busy_o frame in progress; done_o sticky done.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         tick_i,
    input  logic         en_i,
    input  logic         srst_i,
    input  logic [N-1:0] data_i,
    output logic         tx_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int unsigned BitW = (N > 1) ? $clog2(N) : 1;

    uart_state_e      state_q, state_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]  bit_idx_q, bit_idx_d;
    logic [N-1:0]     shift_q, shift_d;
    logic             done_q, done_d;
    logic             tx_q, tx_d;
    logic             last_tick;

    assign last_tick = tick_i && (tick_cnt_q == TickW'(Oversample - 1));

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        done_d     = done_q;
        if (srst_i) begin
            state_d    = StIdle;
            tick_cnt_d = '0;
            done_d     = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (en_i) begin
                        shift_d    = data_i;
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        done_d     = 1'b0;
                        state_d    = StStart;
                    end
                end
                StStart: begin
                    if (last_tick) begin
                        tick_cnt_d = '0;
                        state_d    = StData;
                    end else if (tick_i) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (last_tick) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        if (bit_idx_q == BitW'(N - 1)) begin
                            state_d = StStop;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else if (tick_i) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (last_tick) begin
                        tick_cnt_d = '0;
                        done_d     = 1'b1;
                        state_d    = StIdle;
                    end else if (tick_i) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        // Line level follows the next state so tx is glitch-free and registered.
        if (state_d == StStart) begin
            tx_d = 1'b0;
        end else if (state_d == StData) begin
            tx_d = shift_d[0];
        end else begin
            tx_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            done_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;

endmodule

// File: rtl/uart_apb_wrapper.sv
// APB slave wrapping a full-duplex UART: register file, shared baud tick
// counter, one transmitter and one receiver.
// Ports: PCLK/PRESETn clock and synchronous active-low reset; PSEL, PENABLE,
// PWRITE, PADDR (only [2:0] decoded), PWDATA, PRDATA, PREADY (always 1) form the
// APB slave; rx serial input (idles high); tx serial output (idles high).
module uart_apb_wrapper
    import uart_pkg::*;
#(
    parameter int unsigned N            = 8,
    parameter int unsigned DEFAULT_LOAD = 650
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        rx,
    output logic        tx
);

    logic [3:0]       ctrl_q, ctrl_d;
    logic [N-1:0]     tx_data_q, tx_data_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [BaudW-1:0] cnt_q, cnt_d;
    logic [2:0]       addr;
    logic             wr_en, run, tick;
    logic             tx_busy, tx_done, rx_busy, rx_done, rx_err;
    logic [N-1:0]     rx_data;
    logic             unused_bus;

    assign addr       = PADDR[2:0];
    assign wr_en      = PSEL && PENABLE && PWRITE;
    assign PREADY     = 1'b1;
    assign unused_bus = ^{PADDR[31:3], PWDATA[31:BaudW]};

    // Register writes; read-only and unmapped indices fall through.
    always_comb begin
        ctrl_d    = ctrl_q;
        tx_data_d = tx_data_q;
        baud_d    = baud_q;
        if (wr_en) begin
            case (addr)
                RegCtrl:   ctrl_d    = PWDATA[3:0];
                RegTxData: tx_data_d = PWDATA[N-1:0];
                RegBaud:   baud_d    = PWDATA[BaudW-1:0];
                default:   ;
            endcase
        end
    end

    // Busy cores keep the counter alive so a frame always completes after its
    // enable is dropped. The >= keeps the period sane when BAUD is lowered
    // below the current count.
    assign run  = ctrl_q[CtrlTxEn] || ctrl_q[CtrlRxEn] || tx_busy || rx_busy;
    assign tick = run && (cnt_q >= baud_q);

    always_comb begin
        if (!run || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            ctrl_q    <= '0;
            tx_data_q <= '0;
            baud_q    <= BaudW'(DEFAULT_LOAD);
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            tx_data_q <= tx_data_d;
            baud_q    <= baud_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (addr)
                RegCtrl:   PRDATA[3:0] = ctrl_q;
                RegStatus: begin
                    PRDATA[StatTxBusy] = tx_busy;
                    PRDATA[StatTxDone] = tx_done;
                    PRDATA[StatRxBusy] = rx_busy;
                    PRDATA[StatRxDone] = rx_done;
                    PRDATA[StatRxErr]  = rx_err;
                end
                RegTxData: PRDATA[N-1:0]     = tx_data_q;
                RegRxData: PRDATA[N-1:0]     = rx_data;
                RegBaud:   PRDATA[BaudW-1:0] = baud_q;
                default:   PRDATA = '0;
            endcase
        end
    end

    uart_tx_core #(
        .N(N)
    ) u_tx (
        .clk_i  (PCLK),
        .rst_ni (PRESETn),
        .tick_i (tick),
        .en_i   (ctrl_q[CtrlTxEn]),
        .srst_i (ctrl_q[CtrlTxRst]),
        .data_i (tx_data_q),
        .tx_o   (tx),
        .busy_o (tx_busy),
        .done_o (tx_done)
    );

    uart_rx_core #(
        .N(N)
    ) u_rx (
        .clk_i  (PCLK),
        .rst_ni (PRESETn),
        .tick_i (tick),
        .en_i   (ctrl_q[CtrlRxEn]),
        .srst_i (ctrl_q[CtrlRxRst]),
        .rx_i   (rx),
        .data_o (rx_data),
        .busy_o (rx_busy),
        .done_o (rx_done),
        .err_o  (rx_err)
    );

endmodule

// File: tb/tb_uart_apb_wrapper.sv
// Self-checking bench for uart_apb_wrapper: APB-level register model, an
// independent 16x serial decoder on tx and a serial driver on rx.
`timescale 1ns/1ps
module tb_uart_apb_wrapper;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        rx = 1'b1;
    logic        tx;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Behavioural model state
    int         baud_m = 650;
    logic [3:0] m_ctrl = '0;
    logic [7:0] m_txdata = '0;
    logic [7:0] m_rxdata = '0;
    bit m_tx_busy = 0, m_tx_done = 0, m_rx_busy = 0, m_rx_done = 0, m_rx_err = 0;

    logic [9:0] frame_q[$];
    longint     tx_edge_q[$];
    logic [31:0] rd;

    always #5 PCLK = ~PCLK;

    uart_apb_wrapper #(
        .N(8),
        .DEFAULT_LOAD(650)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .rx      (rx),
        .tx      (tx)
    );

    function automatic int bit_p();
        return 16 * (baud_m + 1);
    endfunction

    function automatic logic [31:0] exp_reg(input logic [2:0] idx);
        case (idx)
            3'd0:    return {28'b0, m_ctrl};
            3'd1:    return {27'b0, m_rx_err, m_rx_done, m_rx_busy, m_tx_done, m_tx_busy};
            3'd2:    return {24'b0, m_txdata};
            3'd3:    return {24'b0, m_rxdata};
            3'd4:    return 32'(baud_m);
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge PCLK);
        #1 PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = addr; PWDATA = data;
        @(posedge PCLK);
        #1 PENABLE = 1;
        @(posedge PCLK);
        #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
        case (addr[2:0])
            3'd0: m_ctrl = data[3:0];
            3'd2: m_txdata = data[7:0];
            3'd4: baud_m = int'(data[9:0]);
            default: ;
        endcase
    endtask

    task automatic apb_read(input logic [31:0] addr, input string name, output logic [31:0] val);
        @(posedge PCLK);
        #1 PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = addr;
        @(posedge PCLK);
        #1 PENABLE = 1;
        #2 val = PRDATA;
        check(name, PRDATA, exp_reg(addr[2:0]));
        @(posedge PCLK);
        #1 PSEL = 0; PENABLE = 0;
    endtask

    // Serial driver: start, 8 data bits LSB first, stop of the given level.
    task automatic send_rx(input logic [7:0] d, input logic stop);
        int p;
        p = bit_p();
        @(posedge PCLK);
        #1 rx = 1'b0;
        repeat (p) @(posedge PCLK);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (p) @(posedge PCLK);
        end
        #1 rx = stop;
        repeat (p) @(posedge PCLK);
        #1 rx = 1'b1;
    endtask

    // Send one frame from the DUT and check its decoded bits and bit timing.
    task automatic run_tx(input logic [7:0] d);
        logic [9:0] e;
        logic [31:0] v;
        int p, w;
        int pos[$];
        p = bit_p();
        e = {1'b1, d, 1'b0};
        apb_write(32'd2, {24'b0, d});
        tx_edge_q.delete();
        frame_q.delete();
        m_tx_busy = 1; m_tx_done = 0;
        apb_write(32'd0, 32'hC);
        apb_write(32'd0, 32'h4);   // one frame only; it still runs to completion
        repeat (2 * p) @(posedge PCLK);
        apb_read(32'd1, "status_tx_busy", v);
        w = 0;
        while (frame_q.size() == 0 && w < 12 * p) begin
            @(posedge PCLK);
            w++;
        end
        repeat (p) @(posedge PCLK);
        m_tx_busy = 0; m_tx_done = 1;
        apb_read(32'd1, "status_tx_done", v);
        check("tx_frame_count", frame_q.size(), 1);
        if (frame_q.size() > 0) check("tx_frame_bits", frame_q[0], e);
        for (int k = 1; k < 10; k++) if (e[k] != e[k-1]) pos.push_back(k);
        check("tx_edge_count", tx_edge_q.size(), pos.size() + 1);
        if (tx_edge_q.size() == pos.size() + 1) begin
            for (int i = 1; i < pos.size(); i++)
                check("tx_bit_timing", (tx_edge_q[i+1] - tx_edge_q[1]) / 10,
                      (pos[i] - pos[0]) * p);
        end
    endtask

    // Independent decoder on tx: mid-bit sampling from the falling start edge.
    initial begin : tx_monitor
        logic [9:0] fb;
        int p;
        forever begin
            @(negedge tx);
            p = bit_p();
            repeat (p / 2) @(posedge PCLK);
            #1 fb[0] = tx;
            for (int i = 1; i < 10; i++) begin
                repeat (p) @(posedge PCLK);
                #1 fb[i] = tx;
            end
            frame_q.push_back(fb);
        end
    end

    always @(tx) tx_edge_q.push_back($time);

    // Per-cycle compare: PREADY, idle PRDATA and idle tx level.
    always @(negedge PCLK) begin
        if (chk_on) begin
            checks++;
            if (PREADY !== 1'b1 || (!PSEL && PRDATA !== 32'h0) || (!m_tx_busy && tx !== 1'b1)) begin
                errors++;
                $display("FAIL cycle_check t=%0t: PREADY=%b PRDATA=%h tx=%b required PREADY=1, PRDATA=0 when idle, tx=1 when no frame",
                         $time, PREADY, PRDATA, tx);
            end
        end
    end

    initial begin : watchdog
        #3ms;
        errors++;
        $display("FAIL watchdog: time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK);
        #1 chk_on = 1'b1;

        // Reset values
        check("tx_reset", tx, 1'b1);
        check("pready", PREADY, 1'b1);
        for (int i = 0; i < 8; i++) apb_read(32'(i), "reset_read", rd);
        apb_read(32'd4, "baud_reset", rd);
        check("baud_reset_lit", rd, 32'd650);

        // Read-only / unmapped writes ignored; upper address bits ignored
        apb_write(32'd1, 32'hFF);
        apb_write(32'd3, 32'hFF);
        apb_write(32'd5, 32'hFFFF_FFFF);
        apb_write(32'h104, 32'd10);
        apb_read(32'd1, "status_ro", rd);
        apb_read(32'd3, "rxdata_ro", rd);
        apb_read(32'd5, "idx5_zero", rd);
        apb_read(32'd4, "baud_10", rd);
        check("baud_10_lit", rd, 32'd10);

        // TX path with literal pattern and 176-cycle bit time
        run_tx(8'h45);
        if (frame_q.size() > 0) check("tx_pattern_lit", frame_q[0], 10'b1010001010);
        if (tx_edge_q.size() > 2) check("bit_time_176", (tx_edge_q[2] - tx_edge_q[1]) / 10, 176);

        // Soft reset mid-frame, then a clean restart
        apb_write(32'd2, 32'h00);
        m_tx_busy = 1; m_tx_done = 0;
        apb_write(32'd0, 32'hC);
        repeat (3 * bit_p()) @(posedge PCLK);
        #1 check("tx_low_before_abort", tx, 1'b0);
        apb_write(32'd0, 32'hE);
        @(posedge PCLK);
        #1 check("tx_idle_after_abort", tx, 1'b1);
        m_tx_busy = 0;
        apb_read(32'd1, "status_after_abort", rd);
        check("status_abort_lit", rd, 32'h0);
        repeat (10 * bit_p()) @(posedge PCLK);
        run_tx(8'h3C);

        // RX good frame
        fork
            send_rx(8'h54, 1'b1);
            begin
                repeat (3 * bit_p()) @(posedge PCLK);
                m_rx_busy = 1; m_rx_done = 0; m_rx_err = 0;
                apb_read(32'd1, "status_rx_busy", rd);
            end
        join
        repeat (4) @(posedge PCLK);
        m_rx_busy = 0; m_rx_done = 1; m_rxdata = 8'h54;
        apb_read(32'd3, "rx_data", rd);
        check("rx_data_lit", rd, 32'h54);
        apb_read(32'd1, "status_rx_done", rd);
        check("status_rx_done_lit", rd, 32'h0A);

        // Framing error: data kept, done cleared, err set
        send_rx(8'h99, 1'b0);
        repeat (4) @(posedge PCLK);
        m_rx_done = 0; m_rx_err = 1;
        apb_read(32'd3, "rx_data_kept", rd);
        check("rx_data_kept_lit", rd, 32'h54);
        apb_read(32'd1, "status_rx_err", rd);
        check("status_rx_err_lit", rd, 32'h12);

        // RX soft reset clears flags, keeps data
        apb_write(32'd0, 32'h5);
        m_rx_err = 0;
        apb_read(32'd1, "status_rx_rst", rd);
        check("status_rx_rst_lit", rd, 32'h02);
        apb_read(32'd3, "rx_data_after_rst", rd);
        apb_write(32'd0, 32'h4);

        // One-tick glitch: enters START briefly, then rejected
        @(posedge PCLK);
        #1 rx = 1'b0;
        repeat (baud_m + 1) @(posedge PCLK);
        #1 rx = 1'b1;
        repeat (30) @(posedge PCLK);
        m_rx_busy = 1;
        apb_read(32'd1, "status_glitch_start", rd);
        repeat (2 * bit_p()) @(posedge PCLK);
        m_rx_busy = 0;
        apb_read(32'd1, "status_glitch_rejected", rd);
        check("status_glitch_lit", rd, 32'h02);
        apb_read(32'd3, "rx_data_after_glitch", rd);

        // Faster baud
        apb_write(32'd4, 32'd4);
        apb_read(32'd4, "baud_4", rd);
        check("baud_4_lit", rd, 32'd4);
        run_tx(8'hA5);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_apb_wrapper.md
Name: uart_apb_wrapper

Overview:
- APB slave that wraps a full-duplex UART: one transmitter, one receiver and a shared baud-tick divisor, all controlled through a small register file.
- Sits on the peripheral APB bus and drives the serial pins tx/rx directly.
- Frame format: 1 start bit (0), N data bits LSB first, 1 stop bit (1), no parity. Receiver uses 16x oversampling.

Parameters:
- N, 8, data bits per frame; width of the TX_DATA and RX_DATA fields.
- DEFAULT_LOAD, 650, reset value of the baud divisor. 650 gives roughly 9600 baud at 16x with a 100 MHz PCLK.

Ports:
- PCLK  in  1  system clock; every flop is on its rising edge.
- PRESETn  in  1  synchronous, active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  word index. Only PADDR[2:0] is decoded; all other bits are ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied to 1 (zero wait states).
- rx  in  1  serial input; idles high.
- tx  out  1  serial output; idles high.

Behaviour:
- Clock and reset: one clock domain. PRESETn is synchronous and active-low.
- Register map (index, field):
  - 0 CTRL: [3] tx_en, [2] rx_en, [1] tx_rst, [0] rx_rst.
  - 1 STATUS, read-only: [0] tx_busy, [1] tx_done, [2] rx_busy, [3] rx_done, [4] rx_err.
  - 2 TX_DATA: [N-1:0].
  - 3 RX_DATA, read-only: [N-1:0].
  - 4 BAUD: [9:0].
  - Indices 5–7 read 0; writes to them are ignored.
- Reset values: CTRL=0, TX_DATA=0, RX_DATA=0, BAUD=DEFAULT_LOAD, all STATUS flags 0, tx=1, PRDATA=0.
- APB write: commits on the PCLK edge where PSEL & PENABLE & PWRITE. Writes to read-only registers are ignored.
- APB read: PRDATA is combinational and shows the addressed register while PSEL & !PWRITE; otherwise PRDATA=0. Unused bits read 0.
- Baud tick:
  - A counter runs 0..BAUD; tick asserts for one cycle when the counter equals BAUD, and the counter then returns to 0. Tick period is BAUD+1 cycles.
  - One bit time is 16 ticks.
  - The counter free-runs whenever tx_en or rx_en is set; otherwise it is held at 0.
- TX state machine: IDLE → START → DATA → STOP → IDLE.
  - In IDLE, if tx_en=1 and tx_rst=0: latch TX_DATA into a shift register and enter START.
  - START drives 0 for 16 ticks. DATA drives bits 0..N-1, each for 16 ticks. STOP drives 1 for 16 ticks.
  - tx_busy is 1 in every state other than IDLE.
  - At the end of STOP: tx_done is set (sticky) and the machine returns to IDLE.
  - If tx_en is still 1, the next frame starts immediately, back-to-back, using the current TX_DATA.
  - tx_done clears at the next frame start.
- RX input: rx passes through a 2-flop synchronizer whose flops reset to 1.
- RX state machine: IDLE → START → DATA → STOP → IDLE.
  - In IDLE, with rx_en=1 and rx_rst=0, a falling edge on the synchronized input enters START.
  - START: at tick 8, sample the line. If it is 1 (glitch), return to IDLE. Otherwise, from there sample every 16 ticks.
  - DATA: N samples, shifted in LSB first.
  - STOP: take one more sample.
    - Sample 1: RX_DATA is updated, rx_done is set, rx_err is cleared.
    - Sample 0: RX_DATA is left unchanged and rx_err is set.
  - rx_busy is 1 in every state other than IDLE.
  - rx_done and rx_err are sticky; they clear at the next valid start bit or on rx_rst.
- Soft resets:
  - tx_rst=1 forces TX to IDLE, tx=1 and tx_done=0, and blocks new frames. It has priority over tx_en.
  - rx_rst=1 forces RX to IDLE and clears rx_done and rx_err; RX_DATA is retained. It has priority over rx_en.
  - Asserting either soft reset mid-frame aborts that frame on the next cycle.
- Changing BAUD or TX_DATA mid-frame affects only subsequent ticks or frames; the current frame's data is already latched.
- Disabling mid-frame: clearing tx_en or rx_en mid-frame lets the current frame finish; no new frame starts.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, STOP);
  - the register index constants (0..4);
  - the CTRL and STATUS bit positions;
  - OVERSAMPLE=16.
- Sub-modules:
  - uart_tx_core: takes tick, en, rst and data; drives tx, busy and done.
  - uart_rx_core: takes tick, en, rst and rx; drives data, done, busy and err.
- The top level holds the APB register file, the baud tick counter and the two core instances.

Test Plan:
- Reset: pulse PRESETn low → every register reads its reset value, BAUD reads 650, tx=1, PREADY=1.
- TX path: write TX_DATA=0x45, then CTRL=0xC → tx shows bit pattern 0,1,0,1,0,0,0,1,0,1 at 651×16 cycles per bit. An external 16x receiver captures 0x45, and tx_done=1 after 10 bit times.
- RX path: an external transmitter sends 0x54 at the same baud with CTRL=0xC → after the stop bit, a read of index 3 returns 0x54 and STATUS[3]=1, STATUS[4]=0.
- Framing error: drive a frame with stop bit 0 → rx_err=1, RX_DATA unchanged, rx_done not set.
- Soft reset mid-frame: write CTRL=0xE in the middle of a TX frame → tx returns to 1 the next cycle and tx_busy=0. Writing CTRL=0xC restarts a full frame.
- Glitch and BAUD: a 1-tick low pulse on rx → no frame is started. Write BAUD=10, then read it back as 10 → the bit time becomes 176 cycles.
